// File: rtl/minterm_scanner.sv
// Truth-table scanner: walks x_out through every code, samples y_in after SETTLE
// wait cycles and priority-encodes the table. Optional macro: SCAN_COMPARE_EN.
module minterm_scanner #(
    parameter int N_IN   = 5,
    parameter int SETTLE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic [N_IN-1:0]         x_out,
    input  logic                    y_in,
`ifdef SCAN_COMPARE_EN
    input  logic [(1<<N_IN)-1:0]    exp_table,
    output logic                    mismatch,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [(1<<N_IN)-1:0]    table_out,
    output logic [N_IN:0]           ones_cnt,
    output logic [N_IN-1:0]         first_idx,
    output logic                    none
);

    localparam int TBL = 1 << N_IN;
    localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'(TBL - 1);
    localparam logic [3:0] SETTLE_W = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [N_IN:0]      idx_q, idx_d;
    logic [N_IN-1:0]    x_q, x_d;
    logic [3:0]         wait_q, wait_d;
    logic [TBL-1:0]     shadow_q, shadow_d;
    logic [N_IN:0]      run_ones_q, run_ones_d;
    logic [N_IN-1:0]    run_first_q, run_first_d;
    logic               found_q, found_d;
    logic               load_res;
    logic [N_IN:0]      idx_next;

    logic [TBL-1:0]     table_q;
    logic [N_IN:0]      ones_q;
    logic [N_IN-1:0]    first_q;
    logic               none_q;

    assign idx_next = idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_d         = x_q;
        wait_d      = wait_q;
        shadow_d    = shadow_q;
        run_ones_d  = run_ones_q;
        run_first_d = run_first_q;
        found_d     = found_q;
        load_res    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d       = '0;
                    x_d         = '0;
                    shadow_d    = '0;
                    run_ones_d  = '0;
                    run_first_d = '0;
                    found_d     = 1'b0;
                    wait_d      = SETTLE_W;
                    state_d     = (SETTLE == 0) ? SAMPLE : WAIT;
                end
            end
            WAIT: begin
                // Leaving on the last counted cycle keeps each code at exactly SETTLE+1 cycles.
                if (wait_q <= 4'd1) begin
                    wait_d  = '0;
                    state_d = SAMPLE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            SAMPLE: begin
                shadow_d[idx_q[N_IN-1:0]] = y_in;
                run_ones_d = run_ones_q + (N_IN+1)'(y_in);
                if (y_in && !found_q) begin
                    run_first_d = idx_q[N_IN-1:0];
                    found_d     = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    load_res = 1'b1;
                    state_d  = FINISH;
                end else begin
                    idx_d   = idx_next;
                    x_d     = idx_next[N_IN-1:0];
                    wait_d  = SETTLE_W;
                    state_d = (SETTLE == 0) ? SAMPLE : WAIT;
                end
            end
            FINISH: begin
                x_d     = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            x_q         <= '0;
            wait_q      <= '0;
            shadow_q    <= '0;
            run_ones_q  <= '0;
            run_first_q <= '0;
            found_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            wait_q      <= wait_d;
            shadow_q    <= shadow_d;
            run_ones_q  <= run_ones_d;
            run_first_q <= run_first_d;
            found_q     <= found_d;
        end
    end

    // Results take the final sample directly from the _d values so they are valid in FINISH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            table_q <= '0;
            ones_q  <= '0;
            first_q <= '0;
            none_q  <= 1'b0;
        end else if (load_res) begin
            table_q <= shadow_d;
            ones_q  <= run_ones_d;
            first_q <= run_first_d;
            none_q  <= (run_ones_d == '0);
        end
    end

`ifdef SCAN_COMPARE_EN
    logic mismatch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
        end else if (load_res) begin
            mismatch_q <= (shadow_d != exp_table);
        end
    end

    assign mismatch = mismatch_q;
`endif

    assign x_out     = x_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign table_out = table_q;
    assign ones_cnt  = ones_q;
    assign first_idx = first_q;
    assign none      = none_q;

endmodule

// File: tb/tb_minterm_scanner.sv
// Scoreboard bench for minterm_scanner: directed scans push expected results, a
// negedge monitor pops and compares on every done pulse. Honours SCAN_COMPARE_EN.
module tb_minterm_scanner;

    localparam int N_IN = 5;
    localparam int TBL  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, start, start0;
    logic [N_IN-1:0]   x_out, x0;
    logic              y_in, y0;
    logic              busy, done, busy0, done0;
    logic [TBL-1:0]    table_out, table0;
    logic [N_IN:0]     ones_cnt, ones0;
    logic [N_IN-1:0]   first_idx, first0;
    logic              none, none0;
    logic [TBL-1:0]    expTable;
`ifdef SCAN_COMPARE_EN
    logic              mismatch, mismatch0;
`endif

    minterm_scanner #(.N_IN(N_IN), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_out(x_out), .y_in(y_in),
`ifdef SCAN_COMPARE_EN
        .exp_table(expTable), .mismatch(mismatch),
`endif
        .busy(busy), .done(done), .table_out(table_out), .ones_cnt(ones_cnt),
        .first_idx(first_idx), .none(none)
    );

    minterm_scanner #(.N_IN(N_IN), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .x_out(x0), .y_in(y0),
`ifdef SCAN_COMPARE_EN
        .exp_table(expTable), .mismatch(mismatch0),
`endif
        .busy(busy0), .done(done0), .table_out(table0), .ones_cnt(ones0),
        .first_idx(first0), .none(none0)
    );

    // Combinational stand-in for the block under test, selected by mode.
    int mode;
    always_comb begin
        case (mode)
            0:       y_in = x_out[0];
            1:       y_in = 1'b0;
            2:       y_in = 1'b1;
            3:       y_in = (x_out == 5'd31);
            4:       y_in = x_out[1];
            default: y_in = 1'b0;
        endcase
    end
    assign y0 = x0[0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;
    int startCyc   = 0;

    typedef struct {
        logic [TBL-1:0] tbl;
        int             ones;
        int             first;
        logic           nn;
        logic           mis;
        int             startAt;
    } expect_t;

    expect_t scoreQ[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Pulses start for one cycle; startCyc is the cycle count just after the start edge.
    task automatic applyStimulus(input int m, input bit push, input logic [TBL-1:0] tbl,
                                 input int ones, input int first, input logic nn, input logic mis);
        expect_t e;
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        startCyc = cyc;
        if (push) begin
            e.tbl = tbl; e.ones = ones; e.first = first; e.nn = nn; e.mis = mis; e.startAt = cyc;
            scoreQ.push_back(e);
        end
    endtask

    task automatic waitDone();
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (i == 200) checkOutput("doneTimeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (scoreQ.size() == 0) begin
                checkOutput("unexpectedDone", 64'd1, 64'd0);
            end else begin
                expect_t e;
                e = scoreQ.pop_front();
                checkOutput("latency",   64'(cyc - e.startAt), 64'd64);
                checkOutput("busyAtDone", 64'(busy), 64'd1);
                checkOutput("table",     64'(table_out), 64'(e.tbl));
                checkOutput("onesCnt",   64'(ones_cnt), 64'(e.ones));
                checkOutput("firstIdx",  64'(first_idx), 64'(e.first));
                checkOutput("none",      64'(none), 64'(e.nn));
`ifdef SCAN_COMPARE_EN
                checkOutput("mismatch",  64'(mismatch), 64'(e.mis));
`endif
            end
        end
    end

    initial begin
        int i;
        rst_n    = 1'b0;
        start    = 1'b0;
        start0   = 1'b0;
        mode     = 1;
        expTable = 32'hAAAAAAAA;
        #12;
        checkOutput("rstXOut",  64'(x_out), 64'd0);
        checkOutput("rstBusy",  64'(busy), 64'd0);
        checkOutput("rstDone",  64'(done), 64'd0);
        checkOutput("rstTable", 64'(table_out), 64'd0);
        checkOutput("rstOnes",  64'(ones_cnt), 64'd0);
        checkOutput("rstFirst", 64'(first_idx), 64'd0);
        checkOutput("rstNone",  64'(none), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(0, 1, 32'hAAAAAAAA, 16, 1, 1'b0, 1'b0);
        checkOutput("busyAfterStart", 64'(busy), 64'd1);
        waitDone();
        checkOutput("idleAfterDone", 64'(busy), 64'd0);

        // Abort mid-scan: results must clear immediately.
        applyStimulus(0, 0, '0, 0, 0, 1'b0, 1'b0);
        while (cyc < startCyc + 20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abortXOut",  64'(x_out), 64'd0);
        checkOutput("abortBusy",  64'(busy), 64'd0);
        checkOutput("abortTable", 64'(table_out), 64'd0);
        checkOutput("abortOnes",  64'(ones_cnt), 64'd0);
`ifdef SCAN_COMPARE_EN
        checkOutput("abortMismatch", 64'(mismatch), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(2, 1, 32'hFFFFFFFF, 32, 0, 1'b0, 1'b1);
        waitDone();

        // Rescan with all-zero response; stray starts are ignored and old results hold.
        applyStimulus(1, 1, 32'h00000000, 0, 0, 1'b1, 1'b1);
        for (i = 0; i < 200; i++) begin
            start = (cyc == startCyc + 9) || (cyc == startCyc + 39);
            if (cyc == startCyc + 30) begin
                checkOutput("holdTable", 64'(table_out), 64'hFFFFFFFF);
                checkOutput("holdOnes",  64'(ones_cnt), 64'd32);
            end
            @(negedge clk);
            if (done) break;
        end
        start = 1'b0;
        if (i == 200) checkOutput("doneTimeout", 64'd0, 64'd1);
        @(negedge clk);

        applyStimulus(3, 1, 32'h80000000, 1, 31, 1'b0, 1'b1);
        waitDone();

        applyStimulus(4, 1, 32'hCCCCCCCC, 16, 2, 1'b0, 1'b1);
        waitDone();

        applyStimulus(0, 1, 32'hAAAAAAAA, 16, 1, 1'b0, 1'b0);
        waitDone();

        // Zero-settle instance: one cycle per code.
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        startCyc = cyc;
        for (i = 0; i < 100; i++) begin
            if (done0) break;
            @(negedge clk);
        end
        checkOutput("settle0Latency", 64'(cyc - startCyc), 64'd32);
        checkOutput("settle0Table",   64'(table0), 64'hAAAAAAAA);
        checkOutput("settle0Ones",    64'(ones0), 64'd16);
        checkOutput("settle0First",   64'(first0), 64'd1);
        repeat (3) @(negedge clk);

        checkOutput("scoreboardEmpty", 64'(scoreQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
